// File: rtl/lc3b_types.sv
// Shared LC-3b word type, fetch FSM state encoding and fetch constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    // BR with no condition codes set never branches.
    localparam lc3b_word NOP_WORD_DEF = 16'h0000;
    localparam lc3b_word PC_STEP      = 16'd2;

    function automatic lc3b_word pc_next(input lc3b_word pc);
        return lc3b_word'(pc + PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/execute controls, instruction memory port, decode register.
interface fetch_unit_if;
    import lc3b_types::*;

    logic     load_pc;
    logic     load_de;
    logic     insert_nop;
    logic     mem_read_a;
    logic     br_taken;
    lc3b_word br_target;
    lc3b_word imem_address;
    logic     imem_read;
    lc3b_word imem_rdata;
    logic     imem_resp;
    logic     mem_resp_a;
    lc3b_word de_ir;
    lc3b_word de_pc;
    logic     de_valid;

    modport slave (
        input  load_pc, load_de, insert_nop, mem_read_a, br_taken, br_target,
        input  imem_rdata, imem_resp,
        output imem_address, imem_read, mem_resp_a, de_ir, de_pc, de_valid
    );

    modport master (
        output load_pc, load_de, insert_nop, mem_read_a, br_taken, br_target,
        output imem_rdata, imem_resp,
        input  imem_address, imem_read, mem_resp_a, de_ir, de_pc, de_valid
    );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry word register that parks a fetched word while decode is stalled.
module fetch_buffer
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_load,
    input  logic     i_clear,
    input  lc3b_word i_data,
    output lc3b_word o_data,
    output logic     o_valid
);

    lc3b_word r_data;
    logic     r_valid;

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// LC-3b fetch stage: PC, instruction memory request, redirect handling, decode register.
module fetch_unit
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000,
    parameter lc3b_word NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave bus
);

    fetch_state_t r_state, w_state_nxt;
    lc3b_word     r_pc, w_pc_nxt;
    lc3b_word     r_target, w_target_nxt;
    lc3b_word     r_de_ir, w_de_ir_nxt;
    lc3b_word     r_de_pc, w_de_pc_nxt;
    logic         r_de_valid, w_de_valid_nxt;
    logic         r_first;
    logic         w_resp;
    logic         w_imem_read;
    logic         w_mem_resp_a;
    logic         w_buf_load, w_buf_clear;
    lc3b_word     w_buf_data;
    logic         w_buf_valid;

    fetch_buffer u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_data  (bus.imem_rdata),
        .o_data  (w_buf_data),
        .o_valid (w_buf_valid)
    );

    // A response left over from a request abandoned by reset is dropped.
    assign w_resp = bus.imem_resp & ~(r_first & ~bus.mem_read_a);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_target   <= '0;
            r_de_ir    <= NOP_WORD;
            r_de_pc    <= RESET_PC;
            r_de_valid <= 1'b0;
            r_first    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_target   <= w_target_nxt;
            r_de_ir    <= w_de_ir_nxt;
            r_de_pc    <= w_de_pc_nxt;
            r_de_valid <= w_de_valid_nxt;
            r_first    <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_target_nxt   = r_target;
        w_de_ir_nxt    = r_de_ir;
        w_de_pc_nxt    = r_de_pc;
        w_de_valid_nxt = r_de_valid;
        w_buf_load     = 1'b0;
        w_buf_clear    = 1'b0;
        w_imem_read    = 1'b0;
        w_mem_resp_a   = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_imem_read  = bus.mem_read_a;
                w_mem_resp_a = w_resp;
                if (bus.br_taken) begin
                    w_de_ir_nxt    = NOP_WORD;
                    w_de_valid_nxt = 1'b0;
                    // An outstanding request must drain before the redirect takes effect.
                    if (!w_resp && bus.mem_read_a) begin
                        w_target_nxt = bus.br_target;
                        w_state_nxt  = ST_FLUSH;
                    end else begin
                        w_pc_nxt = bus.br_target;
                    end
                end else if (w_resp) begin
                    if (bus.load_de) begin
                        w_de_ir_nxt    = bus.insert_nop ? NOP_WORD : bus.imem_rdata;
                        w_de_pc_nxt    = pc_next(r_pc);
                        w_de_valid_nxt = ~bus.insert_nop;
                        if (bus.load_pc) begin
                            w_pc_nxt = pc_next(r_pc);
                        end
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (bus.br_taken) begin
                    w_pc_nxt       = bus.br_target;
                    w_de_ir_nxt    = NOP_WORD;
                    w_de_valid_nxt = 1'b0;
                    w_buf_clear    = 1'b1;
                    w_state_nxt    = ST_FETCH;
                end else if (bus.load_de) begin
                    w_de_ir_nxt    = bus.insert_nop ? NOP_WORD : w_buf_data;
                    w_de_pc_nxt    = pc_next(r_pc);
                    w_de_valid_nxt = ~bus.insert_nop & w_buf_valid;
                    if (bus.load_pc) begin
                        w_pc_nxt = pc_next(r_pc);
                    end
                    w_buf_clear = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FLUSH: begin
                w_imem_read = 1'b1;
                if (bus.br_taken) begin
                    w_target_nxt = bus.br_target;
                end
                // Latest redirect wins, even when it arrives with the draining response.
                if (bus.imem_resp) begin
                    w_pc_nxt    = bus.br_taken ? bus.br_target : r_target;
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    assign bus.imem_address = r_pc;
    assign bus.imem_read    = w_imem_read;
    assign bus.mem_resp_a   = w_mem_resp_a;
    assign bus.de_ir        = r_de_ir;
    assign bus.de_pc        = r_de_pc;
    assign bus.de_valid     = r_de_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scenario tasks with a decode-register scoreboard.
module tb_fetch_unit;
    import lc3b_types::*;

    localparam lc3b_word RST_PC = 16'h0000;
    localparam lc3b_word NOP    = 16'h0005;

    typedef struct {
        lc3b_word ir;
        lc3b_word pc;
        logic     valid;
        logic     chk_pc;
    } de_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    de_exp_t  exp_q[$];
    de_exp_t  e;
    lc3b_word m_pc;
    int       n_assert = 0;
    int       n_fail   = 0;

    task automatic drive_idle();
        bus.load_pc    = 1'b0;
        bus.load_de    = 1'b0;
        bus.insert_nop = 1'b0;
        bus.mem_read_a = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = 16'h0000;
        bus.imem_rdata = 16'h0000;
        bus.imem_resp  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        bus.mem_read_a = 1'b1;
        #1;
        n_assert++;
        if (bus.imem_address !== RST_PC) begin
            n_fail++; $display("FAIL reset_addr: got %h want %h", bus.imem_address, RST_PC);
        end
        n_assert++;
        if (bus.de_ir !== NOP || bus.de_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_de: got ir=%h v=%b want ir=%h v=0", bus.de_ir, bus.de_valid, NOP);
        end
        n_assert++;
        if (bus.de_pc !== RST_PC) begin
            n_fail++; $display("FAIL reset_de_pc: got %h want %h", bus.de_pc, RST_PC);
        end
        n_assert++;
        if (bus.imem_read !== 1'b1) begin
            n_fail++; $display("FAIL reset_read: got %b want 1", bus.imem_read);
        end
        @(negedge clk);
        reset = 1'b0;
        m_pc  = RST_PC;
    endtask

    // Straight-line fetch, last word bubbled by insert_nop.
    task automatic test_stream();
        logic nops[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_idle();
            bus.mem_read_a = 1'b1;
            bus.load_pc    = 1'b1;
            bus.load_de    = 1'b1;
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = 16'h1234;
            bus.insert_nop = nops[i];
            #1;
            n_assert++;
            if (bus.imem_address !== m_pc || bus.mem_resp_a !== 1'b1) begin
                n_fail++; $display("FAIL stream_req%0d: got addr=%h resp=%b want addr=%h resp=1",
                                   i, bus.imem_address, bus.mem_resp_a, m_pc);
            end
            exp_q.push_back('{nops[i] ? NOP : 16'h1234, lc3b_word'(m_pc + 16'd2), ~nops[i], 1'b1});
            m_pc = lc3b_word'(m_pc + 16'd2);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_assert++;
            if (bus.de_ir !== e.ir || bus.de_valid !== e.valid || (e.chk_pc && bus.de_pc !== e.pc)) begin
                n_fail++; $display("FAIL stream_de%0d: got ir=%h pc=%h v=%b want ir=%h pc=%h v=%b",
                                   i, bus.de_ir, bus.de_pc, bus.de_valid, e.ir, e.pc, e.valid);
            end
        end
    endtask

    // Decode stall parks the word; spurious responses in HOLD must be ignored.
    task automatic test_hold();
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        bus.load_pc    = 1'b1;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'hABCD;
        #1;
        n_assert++;
        if (bus.mem_resp_a !== 1'b1) begin
            n_fail++; $display("FAIL hold_capture_resp: got %b want 1", bus.mem_resp_a);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.imem_rdata = 16'hFFFF;
            #1;
            n_assert++;
            if (bus.imem_read !== 1'b0 || bus.mem_resp_a !== 1'b0 || bus.imem_address !== m_pc) begin
                n_fail++; $display("FAIL hold_stall%0d: got read=%b resp=%b addr=%h want read=0 resp=0 addr=%h",
                                   i, bus.imem_read, bus.mem_resp_a, bus.imem_address, m_pc);
            end
            n_assert++;
            if (bus.de_ir !== NOP || bus.de_valid !== 1'b0) begin
                n_fail++; $display("FAIL hold_de_kept%0d: got ir=%h v=%b want ir=%h v=0", i, bus.de_ir, bus.de_valid, NOP);
            end
        end
        @(negedge clk);
        bus.imem_resp = 1'b0;
        bus.load_de   = 1'b1;
        exp_q.push_back('{16'hABCD, lc3b_word'(m_pc + 16'd2), 1'b1, 1'b1});
        m_pc = lc3b_word'(m_pc + 16'd2);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_assert++;
        if (bus.de_ir !== e.ir || bus.de_valid !== e.valid || (e.chk_pc && bus.de_pc !== e.pc)) begin
            n_fail++; $display("FAIL hold_release_de: got ir=%h pc=%h v=%b want ir=%h pc=%h v=%b",
                               bus.de_ir, bus.de_pc, bus.de_valid, e.ir, e.pc, e.valid);
        end
        n_assert++;
        if (bus.imem_address !== m_pc) begin
            n_fail++; $display("FAIL hold_release_pc: got %h want %h", bus.imem_address, m_pc);
        end
    endtask

    // Redirect behind an outstanding request; n_br branches land while flushing.
    task automatic test_flush(input int n_br);
        lc3b_word tgts[2] = '{16'h0040, 16'h0080};
        lc3b_word old_pc;
        old_pc = m_pc;
        for (int i = 0; i < n_br; i++) begin
            @(negedge clk);
            drive_idle();
            bus.mem_read_a = (i == 0);
            bus.load_pc    = 1'b1;
            bus.load_de    = 1'b1;
            bus.br_taken   = 1'b1;
            bus.br_target  = tgts[i];
            #1;
            n_assert++;
            if (bus.imem_read !== 1'b1 || bus.mem_resp_a !== 1'b0) begin
                n_fail++; $display("FAIL flush%0d_br%0d_req: got read=%b resp=%b want read=1 resp=0",
                                   n_br, i, bus.imem_read, bus.mem_resp_a);
            end
            exp_q.push_back('{NOP, 16'h0000, 1'b0, 1'b0});
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_assert++;
            if (bus.de_ir !== e.ir || bus.de_valid !== e.valid || bus.imem_address !== old_pc) begin
                n_fail++; $display("FAIL flush%0d_br%0d_bubble: got ir=%h v=%b addr=%h want ir=%h v=0 addr=%h",
                                   n_br, i, bus.de_ir, bus.de_valid, bus.imem_address, e.ir, old_pc);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_assert++;
        if (bus.imem_read !== 1'b1) begin
            n_fail++; $display("FAIL flush%0d_read_held: got %b want 1", n_br, bus.imem_read);
        end
        @(negedge clk);
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        bus.load_de    = 1'b1;
        bus.load_pc    = 1'b1;
        #1;
        n_assert++;
        if (bus.mem_resp_a !== 1'b0) begin
            n_fail++; $display("FAIL flush%0d_late_resp: got %b want 0", n_br, bus.mem_resp_a);
        end
        m_pc = tgts[n_br-1];
        @(posedge clk); #1;
        n_assert++;
        if (bus.imem_address !== m_pc || bus.de_ir !== NOP || bus.de_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush%0d_refetch: got addr=%h ir=%h v=%b want addr=%h ir=%h v=0",
                               n_br, bus.imem_address, bus.de_ir, bus.de_valid, m_pc, NOP);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_assert++;
        if (bus.imem_read !== 1'b0) begin
            n_fail++; $display("FAIL flush%0d_back_to_fetch: got read=%b want 0", n_br, bus.imem_read);
        end
    endtask

    // Branch with a response in FETCH, branch out of HOLD, then a clean HOLD reuse.
    task automatic test_branch();
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        bus.load_pc    = 1'b1;
        bus.load_de    = 1'b1;
        bus.insert_nop = 1'b1;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'h1111;
        bus.br_taken   = 1'b1;
        bus.br_target  = 16'h0100;
        exp_q.push_back('{NOP, 16'h0000, 1'b0, 1'b0});
        m_pc = 16'h0100;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_assert++;
        if (bus.de_ir !== e.ir || bus.de_valid !== e.valid || bus.imem_address !== m_pc) begin
            n_fail++; $display("FAIL br_fetch: got ir=%h v=%b addr=%h want ir=%h v=0 addr=%h",
                               bus.de_ir, bus.de_valid, bus.imem_address, e.ir, m_pc);
        end
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'h2222;
        @(negedge clk);
        drive_idle();
        bus.br_taken  = 1'b1;
        bus.br_target = 16'h0200;
        bus.load_de   = 1'b1;
        bus.load_pc   = 1'b1;
        #1;
        n_assert++;
        if (bus.imem_read !== 1'b0) begin
            n_fail++; $display("FAIL br_hold_read: got %b want 0", bus.imem_read);
        end
        m_pc = 16'h0200;
        @(posedge clk); #1;
        n_assert++;
        if (bus.imem_address !== m_pc || bus.de_valid !== 1'b0 || bus.de_ir !== NOP) begin
            n_fail++; $display("FAIL br_hold: got addr=%h ir=%h v=%b want addr=%h ir=%h v=0",
                               bus.imem_address, bus.de_ir, bus.de_valid, m_pc, NOP);
        end
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'h3333;
        @(negedge clk);
        drive_idle();
        bus.load_de = 1'b1;
        bus.load_pc = 1'b1;
        exp_q.push_back('{16'h3333, lc3b_word'(m_pc + 16'd2), 1'b1, 1'b1});
        m_pc = lc3b_word'(m_pc + 16'd2);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_assert++;
        if (bus.de_ir !== e.ir || bus.de_valid !== e.valid || bus.de_pc !== e.pc || bus.imem_address !== m_pc) begin
            n_fail++; $display("FAIL br_hold_reuse: got ir=%h pc=%h v=%b addr=%h want ir=%h pc=%h v=1 addr=%h",
                               bus.de_ir, bus.de_pc, bus.de_valid, bus.imem_address, e.ir, e.pc, m_pc);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        bus.imem_resp  = 1'b1;
        bus.br_taken   = 1'b1;
        bus.br_target  = 16'hFFFE;
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'h5A5A;
        bus.load_de    = 1'b1;
        bus.load_pc    = 1'b1;
        #1;
        n_assert++;
        if (bus.imem_address !== 16'hFFFE) begin
            n_fail++; $display("FAIL wrap_start: got %h want fffe", bus.imem_address);
        end
        exp_q.push_back('{16'h5A5A, 16'h0000, 1'b1, 1'b1});
        m_pc = 16'h0000;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_assert++;
        if (bus.de_ir !== e.ir || bus.de_valid !== e.valid || bus.de_pc !== e.pc || bus.imem_address !== m_pc) begin
            n_fail++; $display("FAIL wrap: got ir=%h pc=%h v=%b addr=%h want ir=%h pc=%h v=1 addr=%h",
                               bus.de_ir, bus.de_pc, bus.de_valid, bus.imem_address, e.ir, e.pc, m_pc);
        end
    endtask

    // Reset mid-FLUSH; a stray response right after release must be dropped.
    task automatic test_reset_flush();
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        bus.br_taken   = 1'b1;
        bus.br_target  = 16'h0300;
        @(posedge clk); #1;
        n_assert++;
        if (bus.imem_read !== 1'b1) begin
            n_fail++; $display("FAIL rstfl_in_flush: got read=%b want 1", bus.imem_read);
        end
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        n_assert++;
        if (bus.imem_address !== RST_PC || bus.imem_read !== 1'b0 || bus.de_valid !== 1'b0 ||
            bus.de_ir !== NOP || bus.de_pc !== RST_PC) begin
            n_fail++; $display("FAIL rstfl_async: got addr=%h read=%b ir=%h pc=%h v=%b want addr=%h read=0 ir=%h pc=%h v=0",
                               bus.imem_address, bus.imem_read, bus.de_ir, bus.de_pc, bus.de_valid, RST_PC, NOP, RST_PC);
        end
        @(negedge clk);
        reset          = 1'b0;
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = 16'h7777;
        bus.load_de    = 1'b1;
        bus.load_pc    = 1'b1;
        #1;
        n_assert++;
        if (bus.mem_resp_a !== 1'b0) begin
            n_fail++; $display("FAIL rstfl_stray_resp: got %b want 0", bus.mem_resp_a);
        end
        m_pc = RST_PC;
        @(posedge clk); #1;
        n_assert++;
        if (bus.imem_address !== m_pc || bus.de_valid !== 1'b0 || bus.de_ir !== NOP) begin
            n_fail++; $display("FAIL rstfl_after: got addr=%h ir=%h v=%b want addr=%h ir=%h v=0",
                               bus.imem_address, bus.de_ir, bus.de_valid, m_pc, NOP);
        end
        @(negedge clk);
        drive_idle();
        bus.mem_read_a = 1'b1;
        #1;
        n_assert++;
        if (bus.imem_read !== 1'b1) begin
            n_fail++; $display("FAIL rstfl_state: got read=%b want 1", bus.imem_read);
        end
    endtask

    initial begin
        drive_idle();
        m_pc = RST_PC;
        test_reset();
        test_stream();
        test_hold();
        test_flush(1);
        test_flush(2);
        test_branch();
        test_wrap();
        test_reset_flush();
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 16'h0000: instruction word driven to decode when a bubble is inserted (BR, no condition codes).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 load_pc  in  1  PC advance enable from hazard detection.
REQ-006 load_de  in  1  decode-register load enable from hazard detection.
REQ-007 insert_nop  in  1  forces NOP_WORD into decode on the next load.
REQ-008 mem_read_a  in  1  fetch request enable from hazard detection.
REQ-009 br_taken  in  1  redirect strobe from execute.
REQ-010 br_target  in  16  redirect address (lc3b_word).
REQ-011 imem_address  out  16  instruction memory address.
REQ-012 imem_read  out  1  instruction memory read strobe.
REQ-013 imem_rdata  in  16  instruction memory read data.
REQ-014 imem_resp  in  1  instruction memory response, one-cycle pulse.
REQ-015 mem_resp_a  out  1  qualified response returned to hazard detection.
REQ-016 de_ir  out  16  decode-stage instruction register.
REQ-017 de_pc  out  16  address of de_ir plus 2.
REQ-018 de_valid  out  1  de_ir holds a real fetched instruction, not a bubble.

Function
REQ-019 The block SHALL implement three states: FETCH (request issued/outstanding), HOLD (fetched word buffered, awaiting load_de), FLUSH (redirect pending behind an in-flight request).
REQ-020 imem_read SHALL equal mem_read_a in FETCH, 1 in FLUSH, and 0 in HOLD; imem_address SHALL equal pc and stay stable until imem_resp.
REQ-021 mem_resp_a SHALL equal imem_resp in FETCH, and SHALL be 0 in FLUSH and HOLD.
REQ-022 FETCH, imem_resp=1, load_de=1, br_taken=0: de_ir <= (insert_nop ? NOP_WORD : imem_rdata), de_pc <= pc+2, de_valid <= ~insert_nop; if load_pc, pc <= pc+2; stay FETCH.
REQ-023 FETCH, imem_resp=1, load_de=0, br_taken=0: rdata captured into a one-entry buffer; next state HOLD; pc unchanged.
REQ-024 HOLD, load_de=1, br_taken=0: de_ir/de_pc/de_valid loaded from the buffer (insert_nop overrides to NOP as in REQ-022); pc <= pc+2 if load_pc; next state FETCH.
REQ-025 br_taken=1 in FETCH with imem_resp=1, or in HOLD: fetched/buffered word discarded, pc <= br_target, de_ir <= NOP_WORD, de_valid <= 0, next state FETCH.
REQ-026 br_taken=1 in FETCH with imem_resp=0 and imem_read=1: br_target latched; next state FLUSH; de_ir <= NOP_WORD, de_valid <= 0.
REQ-027 FLUSH: a further br_taken SHALL overwrite the latched target (last wins); on imem_resp the data is discarded, pc <= latched target, next state FETCH.
REQ-028 br_taken SHALL take priority over load_de, load_pc and insert_nop in every state.
REQ-029 PC arithmetic is 16-bit modulo; pc+2 from 16'hFFFE SHALL wrap to 16'h0000.
REQ-030 load_de=0 SHALL hold de_ir, de_pc and de_valid unchanged, except for the REQ-025/026 bubble.

Reset
REQ-031 On reset assertion, immediately: pc=RESET_PC, state=FETCH, de_ir=NOP_WORD, de_pc=RESET_PC, de_valid=0, buffer and latched target cleared.
REQ-032 Reset during FLUSH or HOLD SHALL abandon the pending request; any imem_resp in the first cycle after deassertion while mem_read_a was low SHALL be ignored.

Structure
REQ-033 lc3b_word and the state enumeration (fetch_state_t) SHALL live in lc3b_types; NOP_WORD default is a package constant.
REQ-034 One sub-module, fetch_buffer (one-entry word register with valid bit), SHALL hold the HOLD-state word.

Verification
REQ-035 Reset then mem_read_a=1, load_pc=load_de=1, resp each cycle with 16'h1234 -> imem_address 0,2,4; de_ir=16'h1234, de_pc=2, de_valid=1.
REQ-036 Resp 16'hABCD with load_de=0 for 3 cycles -> HOLD, imem_read=0, mem_resp_a=0; load_de=1 -> de_ir=16'hABCD, pc+2.
REQ-037 br_taken, br_target=16'h0040 while resp pending -> FLUSH; late resp discarded; next imem_address=16'h0040; de_valid=0.
REQ-038 Two br_taken in FLUSH (16'h0040 then 16'h0080) -> refetch from 16'h0080.
REQ-039 pc=16'hFFFE, resp with load_pc=1 -> pc=16'h0000, de_pc=16'h0000.
REQ-040 Reset asserted mid-FLUSH -> outputs at reset values same cycle; imem_address=RESET_PC after release.
